tim_hfsm: RTL and testbench
===========================

TIM_HFSM -- requirements
Module: tim_hfsm

Interface
REQ-001 SHALL declare parameters, one per line: name, default, meaning.
  THD, 180, clocks between vact rise and first horizontal clock (6 us at 30 MHz)
  CLAMP_LEN, 20, clamp pulse length in clocks, starting at vact rise
  DUMMY_RST, 12, reset value of the dummy-pixel register
  ACTIVE_RST, 2480, reset value of the active-pixel register
REQ-002 SHALL declare ports, one per line: name, direction, width, meaning.
  clk  in  1  PIXCLK 30 MHz, one pixel per clock
  rst  in  1  asynchronous, active-low reset
  vact  in  1  line-active window from the vertical timing FSM
  a  in  2  register address
  d  in  8  register data
  we  in  1  register write strobe
  h_en  out  1  enable for the horizontal-clock/RG output driver
  clamp  out  1  CDS/ADC black clamp
  pix_valid  out  1  active pixel qualifier
  pix_x  out  12  active pixel index
  line_start  out  1  one-cycle pulse at the first active pixel
  line_done  out  1  one-cycle pulse after the last active pixel
  line_err  out  1  one-cycle pulse when vact falls before the line completes

Function
REQ-003 Register map SHALL be: 00 reserved (write ignored); 01 dummy count [7:0]; 02 active count [11:8] (d[3:0]); 03 active count [7:0].
REQ-004 A write SHALL update the working register on the clk edge where we=1; a write and a line start on the same edge SHALL leave the new value pending for the next line.
REQ-005 Shadow copies of dummy and active counts SHALL latch on the vact rising edge; mid-line writes SHALL NOT affect the current line.
REQ-006 FSM states SHALL be IDLE, HOLD, DUMMY, ACTIVE, WAIT.
REQ-007 IDLE -> HOLD SHALL occur on the vact rising edge, detected by a registered vact compare.
REQ-008 HOLD SHALL last THD clocks with h_en=0; clamp=1 for the first CLAMP_LEN clocks after entering HOLD.
REQ-009 DUMMY SHALL last dummy-count clocks with h_en=1 and pix_valid=0; a count of 0 SHALL go straight to ACTIVE.
REQ-010 ACTIVE SHALL last active-count clocks with h_en=1 and pix_valid=1; pix_x SHALL run 0..N-1 and line_start SHALL pulse with pix_x=0.
REQ-011 ACTIVE SHALL assert line_done for one cycle on the cycle after pix_x=N-1 and enter WAIT; an active count of 0 SHALL skip ACTIVE, with no line_start, and pulse line_done on entering WAIT.
REQ-012 WAIT SHALL hold h_en=0 and pix_valid=0 until vact=0, then enter IDLE.
REQ-013 If vact=0 in HOLD, DUMMY or ACTIVE, the FSM SHALL go to IDLE next cycle, pulse line_err, force h_en, clamp and pix_valid low, and SHALL NOT pulse line_done.
REQ-014 pix_x SHALL hold its last value outside ACTIVE; counters SHALL be 12 bits and SHALL NOT wrap within a line.
REQ-015 All outputs SHALL be registered.

Reset
REQ-016 While rst=0: state=IDLE; h_en, clamp, pix_valid, line_start, line_done and line_err=0; pix_x=0; dummy=DUMMY_RST; active=ACTIVE_RST; shadow copies equal the reset values.
REQ-017 Reset asserted mid-line SHALL take effect immediately; after release, the FSM SHALL wait for a fresh vact rise even if vact is already high.

Structure
REQ-018 A shared package tim_pkg SHALL hold the state encoding, the register addresses and the 30 MHz timing constants (THD, CLAMP_LEN); the vertical FSM SHALL use the same package.
REQ-019 The register file SHALL be one sub-module, tim_hregs: write decode, working registers and shadow latch.

Verification
REQ-020 Reset defaults, vact high for 2672 clocks -> clamp high clocks 0-19 after rise; h_en rises at clock 180; pix_valid 2480 clocks with pix_x 0..2479; line_done exactly once.
REQ-021 Write 01=0x00, 02=0x00, 03=0x10 -> next line has no dummy phase, 16 valid pixels and line_start at the first one.
REQ-022 Write 03=0x20 during ACTIVE -> current line length unchanged; next line has the new count.
REQ-023 vact falls at pix_x=100 -> line_err pulse; pix_valid low next cycle; no line_done; next vact rise starts a normal line.
REQ-024 rst low during DUMMY with vact held high -> outputs zero; no h_en until vact falls and rises again.
REQ-025 Active count 0 -> no pix_valid, no line_start; line_done after the dummy phase.

Source files
------------

// File: rtl/tim_pkg.sv
// Shared horizontal/vertical timing definitions: state encoding, register map
// and 30 MHz pixel-clock timing constants.
package tim_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_DUMMY,
      S_ACTIVE,
      S_WAIT
   } tim_state_e;

   localparam logic [1:0] ADDR_RSVD   = 2'd0;
   localparam logic [1:0] ADDR_DUMMY  = 2'd1;
   localparam logic [1:0] ADDR_ACT_HI = 2'd2;
   localparam logic [1:0] ADDR_ACT_LO = 2'd3;

   // 6 us of horizontal hold at 30 MHz
   localparam int TIM_THD        = 180;
   localparam int TIM_CLAMP_LEN  = 20;
   localparam int TIM_DUMMY_RST  = 12;
   localparam int TIM_ACTIVE_RST = 2480;

endpackage

// File: rtl/tim_hregs.sv
// Line-timing register file: write decode, working registers and the
// per-line shadow copies latched at vact rise.
module tim_hregs
   import tim_pkg::*;
#(
   parameter int DUMMY_RST  = TIM_DUMMY_RST,
   parameter int ACTIVE_RST = TIM_ACTIVE_RST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [1:0]  a,
   input  logic [7:0]  d,
   input  logic        latch,
   output logic [7:0]  dummy_sh,
   output logic [11:0] active_sh
);

   logic [7:0]  dummy_w;
   logic [11:0] active_w;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dummy_w  <= 8'(DUMMY_RST);
         active_w <= 12'(ACTIVE_RST);
      end else if (we) begin
         case (a)
            ADDR_DUMMY:  dummy_w         <= d;
            ADDR_ACT_HI: active_w[11:8]  <= d[3:0];
            ADDR_ACT_LO: active_w[7:0]   <= d;
            default: ;
         endcase
      end
   end

   // shadow samples the pre-edge working value, so a write on the latch edge waits a line
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dummy_sh  <= 8'(DUMMY_RST);
         active_sh <= 12'(ACTIVE_RST);
      end else if (latch) begin
         dummy_sh  <= dummy_w;
         active_sh <= active_w;
      end
   end

endmodule

// File: rtl/tim_hfsm.sv
// Horizontal line-timing FSM: hold/clamp, dummy pixels, active pixels, then
// wait for the end of the vact window.
//
//   state    | meaning
//   S_IDLE   | waiting for a vact rising edge
//   S_HOLD   | THD clocks with horizontal clocks off, clamp at the start
//   S_DUMMY  | dummy pixels clocked out, not qualified
//   S_ACTIVE | active pixels, pix_valid with pix_x index
//   S_WAIT   | line finished, waiting for vact to drop
module tim_hfsm
   import tim_pkg::*;
#(
   parameter int THD        = TIM_THD,
   parameter int CLAMP_LEN  = TIM_CLAMP_LEN,
   parameter int DUMMY_RST  = TIM_DUMMY_RST,
   parameter int ACTIVE_RST = TIM_ACTIVE_RST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vact,
   input  logic [1:0]  a,
   input  logic [7:0]  d,
   input  logic        we,
   output logic        h_en,
   output logic        clamp,
   output logic        pix_valid,
   output logic [11:0] pix_x,
   output logic        line_start,
   output logic        line_done,
   output logic        line_err
);

   tim_state_e  state_q, state_d;
   logic [11:0] cnt_q, cnt_d, pix_x_d;
   logic        vact_q, rise, latch;
   logic        h_en_d, clamp_d, valid_d, start_d, done_d, err_d;
   logic        go_dummy, go_active;
   logic [7:0]  dummy_sh;
   logic [11:0] active_sh;

   tim_hregs #(
      .DUMMY_RST  (DUMMY_RST),
      .ACTIVE_RST (ACTIVE_RST)
   ) u_hregs (
      .clk       (clk),
      .rst       (rst),
      .we        (we),
      .a         (a),
      .d         (d),
      .latch     (latch),
      .dummy_sh  (dummy_sh),
      .active_sh (active_sh)
   );

   assign rise = vact & ~vact_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pix_x_d   = pix_x;
      h_en_d    = 1'b0;
      clamp_d   = 1'b0;
      valid_d   = 1'b0;
      start_d   = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      latch     = 1'b0;
      go_dummy  = 1'b0;
      go_active = 1'b0;
      unique case (state_q)
         S_IDLE: if (rise) begin
            state_d = S_HOLD;
            cnt_d   = 12'(THD - 1);
            clamp_d = (CLAMP_LEN > 0);
            latch   = 1'b1;
         end
         S_HOLD: begin
            if (!vact) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else if (cnt_q == 12'd0) begin
               if (dummy_sh != 8'd0) go_dummy = 1'b1;
               else                  go_active = 1'b1;
            end else begin
               cnt_d   = cnt_q - 12'd1;
               clamp_d = (12'(THD) - cnt_q) < 12'(CLAMP_LEN);
            end
         end
         S_DUMMY: begin
            if (!vact) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else if (cnt_q == 12'd0) begin
               go_active = 1'b1;
            end else begin
               cnt_d  = cnt_q - 12'd1;
               h_en_d = 1'b1;
            end
         end
         S_ACTIVE: begin
            if (!vact) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else if (cnt_q == 12'd0) begin
               state_d = S_WAIT;
               done_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q - 12'd1;
               pix_x_d = pix_x + 12'd1;
               h_en_d  = 1'b1;
               valid_d = 1'b1;
            end
         end
         S_WAIT: if (!vact) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (go_dummy) begin
         state_d = S_DUMMY;
         cnt_d   = {4'd0, dummy_sh} - 12'd1;
         h_en_d  = 1'b1;
      end
      if (go_active) begin
         if (active_sh != 12'd0) begin
            state_d = S_ACTIVE;
            cnt_d   = active_sh - 12'd1;
            pix_x_d = 12'd0;
            h_en_d  = 1'b1;
            valid_d = 1'b1;
            start_d = 1'b1;
         end else begin
            state_d = S_WAIT;
            done_d  = 1'b1;
         end
      end
   end

   // vact_q resets high so a vact already high at release is not taken as a rise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 12'd0;
         vact_q     <= 1'b1;
         h_en       <= 1'b0;
         clamp      <= 1'b0;
         pix_valid  <= 1'b0;
         pix_x      <= 12'd0;
         line_start <= 1'b0;
         line_done  <= 1'b0;
         line_err   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         vact_q     <= vact;
         h_en       <= h_en_d;
         clamp      <= clamp_d;
         pix_valid  <= valid_d;
         pix_x      <= pix_x_d;
         line_start <= start_d;
         line_done  <= done_d;
         line_err   <= err_d;
      end
   end

endmodule

// File: tb/tb_tim_hfsm.sv
// Self-checking bench for tim_hfsm: per-line expectations are queued when a
// line is driven and compared against tallies of the observed outputs.
module tb_tim_hfsm;

   localparam int THD   = 180;
   localparam int CLAMP = 20;

   logic        clk = 1'b0;
   logic        rst, vact, we;
   logic [1:0]  a;
   logic [7:0]  d;
   logic        h_en, clamp, pix_valid, line_start, line_done, line_err;
   logic [11:0] pix_x;

   tim_hfsm dut (
      .clk        (clk),
      .rst        (rst),
      .vact       (vact),
      .a          (a),
      .d          (d),
      .we         (we),
      .h_en       (h_en),
      .clamp      (clamp),
      .pix_valid  (pix_valid),
      .pix_x      (pix_x),
      .line_start (line_start),
      .line_done  (line_done),
      .line_err   (line_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int clamp_n;
      int clamp_last;
      int hen_first;
      int valid_n;
      int start_n;
      int done_n;
      int done_at;
      int err_n;
      int err_at;
   } line_t;

   line_t exp_q[$];
   line_t obs;
   int    n_chk = 0, n_err = 0;
   int    k, exp_x, x_bad, post_bad;
   int    dummy_w = 12, active_w = 2480;

   task automatic chk(string tag, int act, int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic clear_obs();
      obs = '{clamp_n: 0, clamp_last: -1, hen_first: -1, valid_n: 0, start_n: 0,
              done_n: 0, done_at: -1, err_n: 0, err_at: -1};
      x_bad = 0; post_bad = 0; exp_x = 0; k = 0;
   endtask

   // one clock: sample outputs 1 time unit after the edge, tally as cycle k
   task automatic step();
      @(posedge clk); #1;
      if (clamp) begin obs.clamp_n++; obs.clamp_last = k; end
      if (h_en && obs.hen_first < 0) obs.hen_first = k;
      if (pix_valid) begin
         if (int'(pix_x) != exp_x) x_bad++;
         exp_x++;
         obs.valid_n++;
      end
      if (line_start) begin
         obs.start_n++;
         if (pix_x != 12'd0 || !pix_valid) x_bad++;
      end
      if (line_done) begin obs.done_n++; obs.done_at = k; end
      if (line_err)  begin obs.err_n++;  obs.err_at = k;  end
      if (obs.err_n > 0 && (h_en || pix_valid || clamp)) post_bad++;
      k++;
   endtask

   task automatic model_write(logic [1:0] wa, logic [7:0] wd);
      case (wa)
         2'd1: dummy_w  = int'(wd);
         2'd2: active_w = ((int'(wd) & 15) << 8) | (active_w & 255);
         2'd3: active_w = (active_w & 'hF00) | int'(wd);
         default: ;
      endcase
   endtask

   task automatic reg_write(logic [1:0] wa, logic [7:0] wd);
      a = wa; d = wd; we = 1'b1;
      step();
      we = 1'b0;
      model_write(wa, wd);
   endtask

   // expectation for a line whose vact is seen high on L consecutive edges
   task automatic push_exp(int L);
      line_t e;
      int dn = dummy_w, an = active_w, last = THD + dummy_w + active_w;
      int v;
      e.clamp_n    = (CLAMP < THD) ? CLAMP : THD;
      if (L < e.clamp_n) e.clamp_n = L;
      e.clamp_last = e.clamp_n - 1;
      if (L <= last) begin
         v = L - (THD + dn);
         if (v < 0)  v = 0;
         if (v > an) v = an;
         e.valid_n   = v;
         e.start_n   = (an > 0 && L > THD + dn) ? 1 : 0;
         e.hen_first = (dn + an > 0 && L > THD) ? THD : -1;
         e.done_n = 0; e.done_at = -1;
         e.err_n  = 1; e.err_at  = L;
      end else begin
         e.valid_n   = an;
         e.start_n   = (an > 0) ? 1 : 0;
         e.hen_first = (dn + an > 0) ? THD : -1;
         e.done_n = 1; e.done_at = last;
         e.err_n  = 0; e.err_at  = -1;
      end
      exp_q.push_back(e);
   endtask

   task automatic run_line(string tag, int L, int wat, logic [1:0] wa, logic [7:0] wd);
      line_t e;
      push_exp(L);
      clear_obs();
      vact = 1'b1;
      we = (wat == 0); a = wa; d = wd;
      while (k < L + 6) begin
         step();
         vact = (k < L);
         we   = (k == wat);
      end
      we = 1'b0;
      if (wat >= 0) model_write(wa, wd);
      e = exp_q.pop_front();
      chk({tag, ".clamp_n"},    obs.clamp_n,    e.clamp_n);
      chk({tag, ".clamp_last"}, obs.clamp_last, e.clamp_last);
      chk({tag, ".hen_first"},  obs.hen_first,  e.hen_first);
      chk({tag, ".valid_n"},    obs.valid_n,    e.valid_n);
      chk({tag, ".start_n"},    obs.start_n,    e.start_n);
      chk({tag, ".done_n"},     obs.done_n,     e.done_n);
      chk({tag, ".done_at"},    obs.done_at,    e.done_at);
      chk({tag, ".err_n"},      obs.err_n,      e.err_n);
      chk({tag, ".err_at"},     obs.err_at,     e.err_at);
      chk({tag, ".pix_x_seq"},  x_bad,          0);
      chk({tag, ".post_err"},   post_bad,       0);
      if (e.valid_n > 0) chk({tag, ".pix_x_hold"}, int'(pix_x), e.valid_n - 1);
   endtask

   task automatic chk_outs_zero(string tag);
      chk({tag, ".h_en"},       int'(h_en),       0);
      chk({tag, ".clamp"},      int'(clamp),      0);
      chk({tag, ".pix_valid"},  int'(pix_valid),  0);
      chk({tag, ".pix_x"},      int'(pix_x),      0);
      chk({tag, ".line_start"}, int'(line_start), 0);
      chk({tag, ".line_done"},  int'(line_done),  0);
      chk({tag, ".line_err"},   int'(line_err),   0);
   endtask

   initial begin
      rst = 1'b0; vact = 1'b0; we = 1'b0; a = 2'd0; d = 8'd0;
      clear_obs();
      repeat (3) step();
      chk_outs_zero("reset");
      rst = 1'b1;
      repeat (3) step();

      run_line("default", 2700, -1, 2'd0, 8'd0);
      run_line("abort_x100", THD + 12 + 101, -1, 2'd0, 8'd0);
      run_line("after_abort", 2700, -1, 2'd0, 8'd0);

      reg_write(2'd1, 8'h00);
      reg_write(2'd2, 8'h00);
      reg_write(2'd3, 8'h10);
      run_line("no_dummy16", 220, -1, 2'd0, 8'd0);
      run_line("midline_wr", 250, 190, 2'd3, 8'h20);
      run_line("new_len32", 250, -1, 2'd0, 8'd0);
      run_line("wr_at_start", 250, 0, 2'd3, 8'h08);
      run_line("len8", 220, -1, 2'd0, 8'd0);

      reg_write(2'd1, 8'h05);
      reg_write(2'd0, 8'hFF);
      run_line("dummy5_len8", 220, -1, 2'd0, 8'd0);
      run_line("abort_hold", 50, -1, 2'd0, 8'd0);
      run_line("abort_dummy", THD + 2, -1, 2'd0, 8'd0);

      reg_write(2'd2, 8'h00);
      reg_write(2'd3, 8'h00);
      run_line("active0", 220, -1, 2'd0, 8'd0);
      reg_write(2'd1, 8'h00);
      run_line("empty_line", 220, -1, 2'd0, 8'd0);

      // reset in the middle of the dummy phase with vact held high
      reg_write(2'd1, 8'h0C);
      clear_obs();
      vact = 1'b1;
      repeat (THD + 5) step();
      chk("pre_rst.h_en", int'(h_en), 1);
      rst = 1'b0;
      #2;
      chk_outs_zero("midline_rst");
      repeat (2) step();
      rst = 1'b1;
      dummy_w = 12; active_w = 2480;
      clear_obs();
      repeat (300) step();
      chk("rst_hold.hen_first", obs.hen_first, -1);
      chk("rst_hold.clamp_n",   obs.clamp_n,   0);
      vact = 1'b0;
      repeat (5) step();
      run_line("post_rst", 2700, -1, 2'd0, 8'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
